// File: rtl/hpi_access_arbiter.sv
// Round-robin arbiter and timing sequencer for the CY7C67200 host-port interface.
// Define HPI_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module hpi_access_arbiter #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2,
  parameter int RESET_CYC   = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [15:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [15:0] req1_rdata,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_reset_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_RECOVER
  } state_t;

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);
  localparam logic [7:0] INIT_LAST  = 8'(RESET_CYC - 1);

  state_t      state_reg;
  logic [3:0]  phase_cnt_reg;
  logic [7:0]  init_cnt_reg;
  logic        last_grant_reg;
  logic        acc_id_reg;
  logic        acc_write_reg;
  logic [15:0] rd_capture_reg;
  logic [15:0] rdata0_reg, rdata1_reg;
  logic        done0_reg, done1_reg;
  logic [1:0]  address_reg;
  logic [15:0] data_out_reg;
  logic        oe_reg, cs_n_reg, r_n_reg, w_n_reg, reset_n_reg;

  logic grant;
  logic accept;
  logic acc_write_next;
  logic [1:0] acc_addr_next;
  logic [15:0] acc_wdata_next;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef HPI_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_reg;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_reg == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_reg == ST_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign acc_write_next = grant ? req1_write : req0_write;
  assign acc_addr_next  = grant ? req1_addr  : req0_addr;
  assign acc_wdata_next = grant ? req1_wdata : req0_wdata;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg      <= ST_INIT;
      phase_cnt_reg  <= 4'd0;
      init_cnt_reg   <= 8'd0;
      last_grant_reg <= 1'b1;
      acc_id_reg     <= 1'b0;
      acc_write_reg  <= 1'b0;
      rd_capture_reg <= 16'h0000;
      rdata0_reg     <= 16'h0000;
      rdata1_reg     <= 16'h0000;
      done0_reg      <= 1'b0;
      done1_reg      <= 1'b0;
      address_reg    <= 2'b00;
      data_out_reg   <= 16'h0000;
      oe_reg         <= 1'b0;
      cs_n_reg       <= 1'b1;
      r_n_reg        <= 1'b1;
      w_n_reg        <= 1'b1;
      reset_n_reg    <= 1'b0;
    end else begin
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg == INIT_LAST) begin
            reset_n_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            init_cnt_reg <= init_cnt_reg + 8'd1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            acc_id_reg     <= grant;
            acc_write_reg  <= acc_write_next;
            last_grant_reg <= grant;
            address_reg    <= acc_addr_next;
            cs_n_reg       <= 1'b0;
            if (acc_write_next) begin
              data_out_reg <= acc_wdata_next;
              oe_reg       <= 1'b1;
            end
            phase_cnt_reg <= SETUP_LD;
            state_reg     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_cnt_reg == 4'd0) begin
            if (acc_write_reg) w_n_reg <= 1'b0;
            else               r_n_reg <= 1'b0;
            phase_cnt_reg <= STROBE_LD;
            state_reg     <= ST_STROBE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end
        end
        ST_STROBE: begin
          if (phase_cnt_reg == 4'd0) begin
            // Pad data is sampled on the edge that closes the read strobe.
            if (!acc_write_reg) rd_capture_reg <= hpi_data_in;
            r_n_reg       <= 1'b1;
            w_n_reg       <= 1'b1;
            phase_cnt_reg <= HOLD_LD;
            state_reg     <= ST_HOLD;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end
        end
        ST_HOLD: begin
          if (phase_cnt_reg == 4'd0) begin
            cs_n_reg <= 1'b1;
            oe_reg   <= 1'b0;
            if (acc_id_reg) begin
              done1_reg <= 1'b1;
              if (!acc_write_reg) rdata1_reg <= rd_capture_reg;
            end else begin
              done0_reg <= 1'b1;
              if (!acc_write_reg) rdata0_reg <= rd_capture_reg;
            end
            phase_cnt_reg <= RECOVER_LD;
            state_reg     <= ST_RECOVER;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end
        end
        ST_RECOVER: begin
          if (phase_cnt_reg == 4'd0) state_reg <= ST_IDLE;
          else                       phase_cnt_reg <= phase_cnt_reg - 4'd1;
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign req0_done    = done0_reg;
  assign req1_done    = done1_reg;
  assign req0_rdata   = rdata0_reg;
  assign req1_rdata   = rdata1_reg;
  assign hpi_address  = address_reg;
  assign hpi_data_out = data_out_reg;
  assign hpi_data_oe  = oe_reg;
  assign hpi_cs_n     = cs_n_reg;
  assign hpi_r_n      = r_n_reg;
  assign hpi_w_n      = w_n_reg;
  assign hpi_reset_n  = reset_n_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Randomized bench for hpi_access_arbiter; a timeline model predicts grants and pin activity per cycle.
module tb_hpi_access_arbiter;

  localparam int S  = 1;
  localparam int ST = 3;
  localparam int H  = 1;
  localparam int R  = 2;
  localparam int RC = 8;
`ifdef HPI_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        req0_valid, req0_write, req0_ready, req0_done;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata, req1_rdata;
  logic [1:0]  hpi_address;
  logic [15:0] hpi_data_out, hpi_data_in;
  logic        hpi_data_oe, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, busy;

  always #5 clk_clk = ~clk_clk;

  hpi_access_arbiter #(
    .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .RECOVER_CYC(R), .RESET_CYC(RC)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .hpi_address(hpi_address), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
    .hpi_data_in(hpi_data_in), .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n),
    .hpi_w_n(hpi_w_n), .hpi_reset_n(hpi_reset_n), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: a timeline of the access in flight.
  int          cyc;
  int          next_free;
  int          t_acc;
  int          stim_n = 0;
  bit          model_live = 1'b0;
  bit          last_grant;
  bit          act;
  bit          a_id, a_wr;
  logic [1:0]  a_addr;
  logic [15:0] a_wdata, a_rd;
  logic [15:0] exp_rdata [2];
  logic [1:0]  exp_addr;
  logic [15:0] exp_dout;
  bit          acc [2];

  bit          r_valid [2];
  bit          r_write [2];
  logic [1:0]  r_addr  [2];
  logic [15:0] r_wdata [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    cyc = 0;
    next_free = RC;
    last_grant = 1'b1;
    act = 1'b0;
    exp_rdata[0] = 16'h0;
    exp_rdata[1] = 16'h0;
    exp_addr = 2'b00;
    exp_dout = 16'h0;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    model_live = 1'b1;
  endtask

  task automatic model_step();
    int off;
    bit idle, g, r0, r1, e_cs, e_rn, e_wn, e_oe, e_d0, e_d1;
    idle = (cyc >= next_free);
    check("hpi_reset_n", hpi_reset_n, (cyc >= RC));
    check("busy", busy, !idle);
    if (req0_valid && req1_valid) g = FIXED ? 1'b0 : !last_grant;
    else                          g = req1_valid;
    r0 = idle && req0_valid && !g;
    r1 = idle && req1_valid && g;
    check("req0_ready", req0_ready, r0);
    check("req1_ready", req1_ready, r1);
    e_cs = 1; e_rn = 1; e_wn = 1; e_oe = 0; e_d0 = 0; e_d1 = 0;
    off = cyc - t_acc;
    if (act) begin
      if (off >= 1 && off <= S + ST + H) e_cs = 0;
      if (off >= S + 1 && off <= S + ST) begin
        if (a_wr) e_wn = 0;
        else      e_rn = 0;
      end
      if (a_wr && off >= 1 && off <= S + ST + H) e_oe = 1;
      if (off == S + ST + H + 1) begin
        if (a_id) e_d1 = 1;
        else      e_d0 = 1;
        if (!a_wr) exp_rdata[a_id] = a_rd;
      end
      if (!a_wr && off == S + ST) a_rd = hpi_data_in;
    end
    check("hpi_cs_n", hpi_cs_n, e_cs);
    check("hpi_r_n", hpi_r_n, e_rn);
    check("hpi_w_n", hpi_w_n, e_wn);
    check("hpi_data_oe", hpi_data_oe, e_oe);
    check("hpi_address", hpi_address, exp_addr);
    check("hpi_data_out", hpi_data_out, exp_dout);
    check("req0_done", req0_done, e_d0);
    check("req1_done", req1_done, e_d1);
    check("req0_rdata", req0_rdata, exp_rdata[0]);
    check("req1_rdata", req1_rdata, exp_rdata[1]);
    acc[0] = r0;
    acc[1] = r1;
    if (r0 || r1) begin
      act = 1'b1;
      t_acc = cyc;
      a_id = g;
      a_wr = g ? req1_write : req0_write;
      a_addr = g ? req1_addr : req0_addr;
      a_wdata = g ? req1_wdata : req0_wdata;
      last_grant = g;
      next_free = cyc + S + ST + H + R + 1;
      exp_addr = a_addr;
      if (a_wr) exp_dout = a_wdata;
      $display("cycle %0d: accept req%0d %s addr=%0d wdata=%h", cyc, g, a_wr ? "write" : "read", a_addr, a_wdata);
    end
    cyc++;
  endtask

  task automatic drive();
    bit warm;
    warm = (stim_n < 40);
    stim_n++;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) r_valid[i] = 1'b0;
      if (!r_valid[i]) begin
        if (!warm && $urandom_range(1, 0) == 1) begin
          r_valid[i] = 1'b1;
          r_write[i] = 1'($urandom_range(1, 0));
          r_addr[i]  = 2'($urandom_range(3, 0));
          r_wdata[i] = 16'($urandom);
        end
      end else if (!warm && $urandom_range(15, 0) == 0) begin
        r_valid[i] = 1'b0;
      end
      acc[i] = 1'b0;
    end
    req0_valid = r_valid[0]; req0_write = r_write[0]; req0_addr = r_addr[0]; req0_wdata = r_wdata[0];
    req1_valid = r_valid[1]; req1_write = r_write[1]; req1_addr = r_addr[1]; req1_wdata = r_wdata[1];
    hpi_data_in = warm ? 16'h1234 : 16'($urandom);
  endtask

  task automatic cycle_run(input bit do_rst);
    @(posedge clk_clk);
    #1;
    drive();
    reset_reset = do_rst;
    @(negedge clk_clk);
    if (model_live) model_step();
    if (do_rst) model_reset();
  endtask

  initial begin
    bit found;
    reset_reset = 1'b1;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    // Opening traffic: a write from requester 0 and a read from requester 1 pending through INIT.
    r_valid[0] = 1'b1; r_write[0] = 1'b1; r_addr[0] = 2'b10; r_wdata[0] = 16'hBEEF;
    r_valid[1] = 1'b1; r_write[1] = 1'b0; r_addr[1] = 2'b00; r_wdata[1] = 16'h0000;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 2'b00; req0_wdata = 16'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'b00; req1_wdata = 16'h0;
    hpi_data_in = 16'h1234;
    repeat (3) cycle_run(1'b1);
    repeat (400) cycle_run(1'b0);

    // Reset during the second strobe cycle of a read.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (act && !a_wr && (cyc - t_acc == S + 2)) begin
        found = 1'b1;
        cycle_run(1'b1);
      end else begin
        cycle_run(1'b0);
      end
    end
    check("mid_read_reset_reached", found, 1'b1);
    repeat (400) cycle_run(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
